// File: rtl/spc700_word_alu.sv
// SPC700 16-bit word ALU sequencer (ADDW/SUBW/CMPW/INCW/DECW).
// The operation uses one shared 8-bit add/sub slice: the low byte on one cycle, then the high byte on the next.
module spc700_word_alu (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE,
   input  logic        START,
   input  logic [2:0]  OP,
   input  logic [15:0] OPA,
   input  logic [15:0] OPB,
   input  logic [7:0]  PSW_IN,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] RES,
   output logic [7:0]  PSW_OUT,
   output logic        WR_YA
);

   localparam logic [2:0] OP_ADDW = 3'd0;
   localparam logic [2:0] OP_SUBW = 3'd1;
   localparam logic [2:0] OP_CMPW = 3'd2;
   localparam logic [2:0] OP_INCW = 3'd3;
   localparam logic [2:0] OP_DECW = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [7:0]  psw_q, psw_d;
   logic [7:0]  lo_q, lo_d;
   logic        c_q, c_d;
   logic        done_q, done_d;
   logic        wr_q, wr_d;
   logic [15:0] res_q, res_d;
   logic [7:0]  pswo_q, pswo_d;

   logic        add;
   logic        sel_hi;
   logic [10:0] slice;
   logic [15:0] word;

   // Returns {half carry, overflow, carry out, sum[7:0]}; B is inverted for subtraction.
   function automatic logic [10:0] byte_slice(input logic [7:0] a, input logic [7:0] b,
                                              input logic is_add, input logic ci);
      logic [7:0] bb;
      logic [8:0] s;
      logic [4:0] h;
      logic       vo;
      bb = is_add ? b : ~b;
      s  = {1'b0, a} + {1'b0, bb} + {8'd0, ci};
      h  = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'd0, ci};
      vo = (a[7] == bb[7]) && (s[7] != a[7]);
      return {h[4], vo, s[8], s[7:0]};
   endfunction

   function automatic logic [7:0] merge_psw(input logic [2:0] op, input logic [7:0] psw,
                                            input logic [15:0] r, input logic v,
                                            input logic h, input logic c);
      logic [7:0] p;
      logic       n;
      logic       z;
      p = psw;
      n = r[15];
      z = (r == 16'h0000);
      case (op)
         OP_ADDW, OP_SUBW: begin
            p[7] = n;
            p[6] = v;
            p[3] = h;
            p[1] = z;
            p[0] = c;
         end
         OP_CMPW: begin
            p[7] = n;
            p[1] = z;
            p[0] = c;
         end
         OP_INCW, OP_DECW: begin
            p[7] = n;
            p[1] = z;
         end
         default: ;
      endcase
      return p;
   endfunction

   assign add    = (op_q == OP_ADDW) || (op_q == OP_INCW);
   assign sel_hi = (state_q == S_HI);
   assign slice  = sel_hi ? byte_slice(a_q[15:8], b_q[15:8], add, c_q)
                          : byte_slice(a_q[7:0],  b_q[7:0],  add, ~add);
   assign word   = {slice[7:0], lo_q};

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      psw_d   = psw_q;
      lo_d    = lo_q;
      c_d     = c_q;
      res_d   = res_q;
      pswo_d  = pswo_q;
      done_d  = 1'b0;
      wr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_LO;
               op_d    = OP;
               a_d     = OPA;
               psw_d   = PSW_IN;
               b_d     = (OP == OP_INCW || OP == OP_DECW) ? 16'h0001 : OPB;
            end
         end
         S_LO: begin
            lo_d    = slice[7:0];
            c_d     = slice[8];
            state_d = S_HI;
         end
         S_HI: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (op_q <= OP_DECW) begin
               res_d  = word;
               pswo_d = merge_psw(op_q, psw_q, word, slice[9], slice[10], slice[8]);
               wr_d   = (op_q != OP_CMPW);
            end else begin
               res_d  = a_q;
               pswo_d = psw_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         op_q    <= 3'd0;
         a_q     <= 16'd0;
         b_q     <= 16'd0;
         psw_q   <= 8'd0;
         lo_q    <= 8'd0;
         c_q     <= 1'b0;
         done_q  <= 1'b0;
         wr_q    <= 1'b0;
         res_q   <= 16'd0;
         pswo_q  <= 8'd0;
      end else if (CE) begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psw_q   <= psw_d;
         lo_q    <= lo_d;
         c_q     <= c_d;
         done_q  <= done_d;
         wr_q    <= wr_d;
         res_q   <= res_d;
         pswo_q  <= pswo_d;
      end
   end

   assign BUSY    = (state_q != S_IDLE);
   assign DONE    = done_q;
   assign WR_YA   = wr_q;
   assign RES     = res_q;
   assign PSW_OUT = pswo_q;

endmodule

// File: tb/tb_spc700_word_alu.sv
// Directed testbench for spc700_word_alu: word ops, flags, CE stall, back-to-back and mid-op reset.
module tb_spc700_word_alu;

   logic        CLK;
   logic        RST;
   logic        CE;
   logic        START;
   logic [2:0]  OP;
   logic [15:0] OPA;
   logic [15:0] OPB;
   logic [7:0]  PSW_IN;
   logic        BUSY;
   logic        DONE;
   logic [15:0] RES;
   logic [7:0]  PSW_OUT;
   logic        WR_YA;

   int errors = 0;
   int checks = 0;

   spc700_word_alu dut (
      .CLK(CLK), .RST(RST), .CE(CE), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
      .PSW_IN(PSW_IN), .BUSY(BUSY), .DONE(DONE), .RES(RES), .PSW_OUT(PSW_OUT), .WR_YA(WR_YA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Starts an op at a falling edge; lat = falling edges until DONE seen (bounded at 20).
   task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] psw, output int lat);
      @(negedge CLK);
      OP = op; OPA = a; OPB = b; PSW_IN = psw; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      lat = 1;
      while (!DONE && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; CE = 1'b1; START = 1'b0; OP = 3'd0; OPA = 16'h5555; OPB = 16'h3333; PSW_IN = 8'hFF;
      repeat (2) @(negedge CLK);
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", DONE); end
      checks++; if (RES !== 16'h0000) begin errors++; $display("FAIL reset_res got=%h exp=0000", RES); end
      checks++; if (PSW_OUT !== 8'h00) begin errors++; $display("FAIL reset_psw got=%h exp=00", PSW_OUT); end
      checks++; if (WR_YA !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", WR_YA); end
      RST = 1'b0;
   endtask

   task automatic test_addw();
      int lat;
      run_op(3'd0, 16'h1234, 16'h0FCC, 8'h00, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL addw_latency got=%0d exp=3", lat); end
      checks++; if (RES !== 16'h2200) begin errors++; $display("FAIL addw_res got=%h exp=2200", RES); end
      checks++; if (PSW_OUT !== 8'h08) begin errors++; $display("FAIL addw_psw got=%h exp=08", PSW_OUT); end
      checks++; if (WR_YA !== 1'b1) begin errors++; $display("FAIL addw_wr got=%b exp=1", WR_YA); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL addw_busy got=%b exp=0", BUSY); end
      @(negedge CLK);
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL addw_done_pulse got=%b exp=0", DONE); end
      checks++; if (WR_YA !== 1'b0) begin errors++; $display("FAIL addw_wr_pulse got=%b exp=0", WR_YA); end
      checks++; if (RES !== 16'h2200) begin errors++; $display("FAIL addw_res_hold got=%h exp=2200", RES); end
   endtask

   task automatic test_subw();
      int lat;
      run_op(3'd1, 16'h8000, 16'h0001, 8'h00, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL subw_latency got=%0d exp=3", lat); end
      checks++; if (RES !== 16'h7FFF) begin errors++; $display("FAIL subw_res got=%h exp=7fff", RES); end
      checks++; if (PSW_OUT !== 8'h41) begin errors++; $display("FAIL subw_psw got=%h exp=41", PSW_OUT); end
      checks++; if (WR_YA !== 1'b1) begin errors++; $display("FAIL subw_wr got=%b exp=1", WR_YA); end
   endtask

   task automatic test_cmpw();
      int lat;
      run_op(3'd2, 16'h1000, 16'h1000, 8'hC8, lat);
      checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL cmpw_done got=%b exp=1", DONE); end
      checks++; if (RES !== 16'h0000) begin errors++; $display("FAIL cmpw_res got=%h exp=0000", RES); end
      checks++; if (PSW_OUT !== 8'h4B) begin errors++; $display("FAIL cmpw_psw got=%h exp=4b", PSW_OUT); end
      checks++; if (WR_YA !== 1'b0) begin errors++; $display("FAIL cmpw_wr got=%b exp=0", WR_YA); end
   endtask

   task automatic test_incdec();
      int lat;
      run_op(3'd3, 16'hFFFF, 16'h1234, 8'h01, lat);
      checks++; if (RES !== 16'h0000) begin errors++; $display("FAIL incw_res got=%h exp=0000", RES); end
      checks++; if (PSW_OUT !== 8'h03) begin errors++; $display("FAIL incw_psw got=%h exp=03", PSW_OUT); end
      checks++; if (WR_YA !== 1'b1) begin errors++; $display("FAIL incw_wr got=%b exp=1", WR_YA); end
      run_op(3'd4, 16'h0000, 16'h5678, 8'h00, lat);
      checks++; if (RES !== 16'hFFFF) begin errors++; $display("FAIL decw_res got=%h exp=ffff", RES); end
      checks++; if (PSW_OUT !== 8'h80) begin errors++; $display("FAIL decw_psw got=%h exp=80", PSW_OUT); end
      checks++; if (WR_YA !== 1'b1) begin errors++; $display("FAIL decw_wr got=%b exp=1", WR_YA); end
   endtask

   task automatic test_reserved();
      int lat;
      run_op(3'd5, 16'hABCD, 16'h1111, 8'h5A, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rsvd_latency got=%0d exp=3", lat); end
      checks++; if (RES !== 16'hABCD) begin errors++; $display("FAIL rsvd_res got=%h exp=abcd", RES); end
      checks++; if (PSW_OUT !== 8'h5A) begin errors++; $display("FAIL rsvd_psw got=%h exp=5a", PSW_OUT); end
      checks++; if (WR_YA !== 1'b0) begin errors++; $display("FAIL rsvd_wr got=%b exp=0", WR_YA); end
   endtask

   task automatic test_ce_stall();
      int lat;
      int dones;
      @(negedge CLK);
      OP = 3'd1; OPA = 16'h5000; OPB = 16'h1234; PSW_IN = 8'h00; START = 1'b1;
      @(negedge CLK);
      START = 1'b0; lat = 1;
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL stall_busy got=%b exp=1", BUSY); end
      CE = 1'b0; START = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         lat++;
         checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL stall_done_frozen got=%b exp=0", DONE); end
      end
      CE = 1'b1; OP = 3'd0; OPA = 16'h1111; OPB = 16'h1111; PSW_IN = 8'hFF; START = 1'b1;
      @(negedge CLK);
      lat++;
      START = 1'b0; OPA = 16'h2222;
      while (!DONE && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      checks++; if (lat !== 6) begin errors++; $display("FAIL stall_latency got=%0d exp=6", lat); end
      checks++; if (RES !== 16'h3DCC) begin errors++; $display("FAIL stall_res got=%h exp=3dcc", RES); end
      checks++; if (PSW_OUT !== 8'h01) begin errors++; $display("FAIL stall_psw got=%h exp=01", PSW_OUT); end
      dones = 0;
      repeat (6) begin
         @(negedge CLK);
         if (DONE) dones++;
      end
      checks++; if (dones !== 0) begin errors++; $display("FAIL stall_extra_done got=%0d exp=0", dones); end
      checks++; if (RES !== 16'h3DCC) begin errors++; $display("FAIL stall_res_hold got=%h exp=3dcc", RES); end
   endtask

   task automatic test_back_to_back();
      int lat;
      run_op(3'd0, 16'h7FFF, 16'h0001, 8'h00, lat);
      checks++; if (RES !== 16'h8000) begin errors++; $display("FAIL b2b_res1 got=%h exp=8000", RES); end
      checks++; if (PSW_OUT !== 8'hC8) begin errors++; $display("FAIL b2b_psw1 got=%h exp=c8", PSW_OUT); end
      OP = 3'd1; OPA = 16'h0001; OPB = 16'h0002; PSW_IN = 8'h00; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", BUSY); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL b2b_done_clear got=%b exp=0", DONE); end
      lat = 1;
      while (!DONE && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
      checks++; if (RES !== 16'hFFFF) begin errors++; $display("FAIL b2b_res2 got=%h exp=ffff", RES); end
      checks++; if (PSW_OUT !== 8'h80) begin errors++; $display("FAIL b2b_psw2 got=%h exp=80", PSW_OUT); end
   endtask

   task automatic test_rst_mid();
      int lat;
      @(negedge CLK);
      OP = 3'd0; OPA = 16'h1234; OPB = 16'h0FCC; PSW_IN = 8'h00; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
      checks++; if (RES !== 16'h0000) begin errors++; $display("FAIL rst_res got=%h exp=0000", RES); end
      checks++; if (PSW_OUT !== 8'h00) begin errors++; $display("FAIL rst_psw got=%h exp=00", PSW_OUT); end
      @(negedge CLK);
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_no_done got=%b exp=0", DONE); end
      RST = 1'b0;
      @(negedge CLK);
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_no_done_after got=%b exp=0", DONE); end
      run_op(3'd3, 16'h00FF, 16'h0000, 8'h83, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL rst_recover_latency got=%0d exp=3", lat); end
      checks++; if (RES !== 16'h0100) begin errors++; $display("FAIL rst_recover_res got=%h exp=0100", RES); end
      checks++; if (PSW_OUT !== 8'h01) begin errors++; $display("FAIL rst_recover_psw got=%h exp=01", PSW_OUT); end
   endtask

   initial begin
      test_reset();
      test_addw();
      test_subw();
      test_cmpw();
      test_incdec();
      test_reserved();
      test_ce_stall();
      test_back_to_back();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
